// File: rtl/bw_io_dtl_flps_pipe.sv
// Scannable WIDTH x DEPTH retiming pipeline for DTL pad signals. It has a
// single scan chain, a shadow register that can override q, and a shift counter.
module bw_io_dtl_flps_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             se,
  input  logic             si,
  input  logic             upd,
  input  logic             ovr,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             scan_done
);

  localparam int              CHAIN_LEN = WIDTH * DEPTH;
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(CHAIN_LEN);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  // All stages are stored as one flat vector. Stage k occupies bits
  // [k*WIDTH +: WIDTH]. This makes the scan order identical to the bit index.
  logic [CHAIN_LEN-1:0] chain_r;
  logic [CHAIN_LEN-1:0] chain_nxt_s;
  logic [WIDTH-1:0]     last_s;
  logic [WIDTH-1:0]     shadow_r;
  logic [CNTW-1:0]      cnt_r;

  assign last_s = chain_r[CHAIN_LEN-1 -: WIDTH];

  // Next chain contents: a scan shift moves by one bit, and a functional
  // advance moves by one stage.
  always_comb begin
    chain_nxt_s = chain_r;
    if (se) begin
      chain_nxt_s = (chain_r << 1'b1) | CHAIN_LEN'(si);
    end else if (en) begin
      chain_nxt_s = (chain_r << WIDTH) | CHAIN_LEN'(d);
    end else begin
      chain_nxt_s = chain_r;
    end
  end

  // Pipeline, shadow and shift-counter state. The shadow samples the
  // pre-edge last stage, so a simultaneous advance does not leak into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r  <= '0;
      shadow_r <= '0;
      cnt_r    <= '0;
    end else begin
      chain_r <= chain_nxt_s;
      if (se) begin
        shadow_r <= shadow_r;
        cnt_r    <= (cnt_r == CNT_FULL) ? CNT_FULL : cnt_r + CNT_ONE;
      end else begin
        cnt_r <= '0;
        if (upd) begin
          shadow_r <= last_s;
        end else begin
          shadow_r <= shadow_r;
        end
      end
    end
  end

  assign q         = ovr ? shadow_r : last_s;
  assign so        = chain_r[CHAIN_LEN-1];
  assign scan_done = (cnt_r == CNT_FULL);

endmodule

// File: tb/tb_bw_io_dtl_flps_pipe.sv
// Self-checking bench for bw_io_dtl_flps_pipe (WIDTH=3, DEPTH=2): a stage-level
// reference model is compared every cycle, together with directed literal checks.
module tb_bw_io_dtl_flps_pipe;

  localparam int W  = 3;
  localparam int D  = 2;
  localparam int L  = W * D;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] d   = '0;
  logic         en  = 1'b0;
  logic         se  = 1'b0;
  logic         si  = 1'b0;
  logic         upd = 1'b0;
  logic         ovr = 1'b0;
  logic [W-1:0] q;
  logic         so;
  logic         scan_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bw_io_dtl_flps_pipe #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .d(d), .en(en), .se(se), .si(si),
    .upd(upd), .ovr(ovr), .q(q), .so(so), .scan_done(scan_done)
  );

  // Reference model: two named stages, a shadow, and an integer shift count.
  logic [W-1:0] stage0_m, stage1_m, shadow_m;
  int           cnt_m;

  // The scan chain is modelled as a bit queue in chain order. A new bit
  // enters at the front, and the oldest bit falls off the end.
  function automatic logic [2*W-1:0] shift_chain(input logic [W-1:0] s0,
                                                 input logic [W-1:0] s1,
                                                 input logic b);
    bit ch[$];
    logic [W-1:0] n0, n1;
    n0 = '0;
    n1 = '0;
    for (int i = 0; i < W; i++) ch.push_back(s0[i]);
    for (int i = 0; i < W; i++) ch.push_back(s1[i]);
    ch.push_front(b);
    void'(ch.pop_back());
    for (int i = 0; i < W; i++) begin
      n0[i] = ch[i];
      n1[i] = ch[W+i];
    end
    return {n1, n0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stage0_m <= '0;
      stage1_m <= '0;
      shadow_m <= '0;
      cnt_m    <= 0;
    end else if (se) begin
      {stage1_m, stage0_m} <= shift_chain(stage0_m, stage1_m, si);
      cnt_m <= (cnt_m == L) ? L : cnt_m + 1;
    end else begin
      cnt_m <= 0;
      if (upd) shadow_m <= stage1_m;
      if (en) begin
        stage0_m <= d;
        stage1_m <= stage0_m;
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    check("model_q", q, ovr ? shadow_m : stage1_m);
    check("model_so", W'(so), W'(stage1_m[W-1]));
    check("model_done", W'(scan_done), W'(cnt_m == L));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] bits_v, so_v, done_v;
    logic [W-1:0] rd;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_q", q, 3'b000);
    check("rst_so", W'(so), 3'b000);
    check("rst_done", W'(scan_done), 3'b000);
    rst = 1'b0;

    // 1. Functional pipeline with a latency of two stages, then hold
    en = 1'b1; d = 3'b101; cyc();
    d = 3'b010; cyc();
    check("t1_e2", q, 3'b101);
    d = 3'b111; cyc();
    check("t1_e3", q, 3'b010);
    d = 3'b000; cyc();
    check("t1_e4", q, 3'b111);
    en = 1'b0; d = 3'b110; cyc(); cyc();
    check("t1_hold", q, 3'b111);

    // 2. Scan shift of 1,0,1,1,0,0. Chain before: stage1=111, stage0=000.
    bits_v = 6'b001101;
    so_v   = 6'b100011;
    done_v = 6'b100000;
    se = 1'b1;
    for (int i = 0; i < 6; i++) begin
      si = bits_v[i];
      cyc();
      check("t2_so", W'(so), W'(so_v[i]));
      check("t2_done", W'(scan_done), W'(done_v[i]));
    end
    check("t2_q", q, 3'b101);
    si = 1'b0; cyc();
    check("t2_done7", W'(scan_done), 3'b001);
    check("t2_q7", q, 3'b011);
    se = 1'b0; cyc();
    check("t2_done_clr", W'(scan_done), 3'b000);

    // 3. Shadow load at the same edge as an advance
    en = 1'b1; d = 3'b110; cyc();
    d = 3'b001; cyc();
    check("t3_pre", q, 3'b110);
    upd = 1'b1; d = 3'b010; cyc();
    upd = 1'b0; en = 1'b0;
    check("t3_pipe", q, 3'b001);
    ovr = 1'b1; #1;
    check("t3_ovr", q, 3'b110);
    ovr = 1'b0; #1;
    check("t3_novr", q, 3'b001);

    // 4. upd is ignored during scan; the counter restarts after se drops
    ovr = 1'b1; se = 1'b1; upd = 1'b1; si = 1'b1;
    repeat (3) cyc();
    check("t4_shadow", q, 3'b110);
    check("t4_done", W'(scan_done), 3'b000);
    se = 1'b0; upd = 1'b0; cyc();
    se = 1'b1;
    repeat (5) cyc();
    check("t4_done5", W'(scan_done), 3'b000);
    cyc();
    check("t4_done6", W'(scan_done), 3'b001);
    se = 1'b0; cyc();

    // 5. Asynchronous reset in the middle of a shift
    en = 1'b1; d = 3'b011; cyc(); cyc();
    en = 1'b0; upd = 1'b1; cyc();
    upd = 1'b0;
    check("t5_shadow", q, 3'b011);
    se = 1'b1; si = 1'b1;
    repeat (4) cyc();
    #2 rst = 1'b1;
    #1;
    check("t5_q", q, 3'b000);
    check("t5_so", W'(so), 3'b000);
    check("t5_done", W'(scan_done), 3'b000);
    ovr = 1'b0; #1;
    check("t5_qpipe", q, 3'b000);
    se = 1'b0; si = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;

    // 6. Hold while d toggles
    en = 1'b1; d = 3'b101; cyc();
    d = 3'b110; cyc();
    en = 1'b0; upd = 1'b1; cyc();
    upd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = W'($urandom);
      cyc();
      check("t6_q", q, 3'b101);
      check("t6_so", W'(so), 3'b001);
    end
    ovr = 1'b1; #1;
    check("t6_shadow", q, 3'b101);
    ovr = 1'b0;

    // Randomized traffic, checked by the model, with occasional async resets
    for (int i = 0; i < 400; i++) begin
      rd  = W'($urandom);
      d   = rd;
      se  = ($urandom_range(0, 2) == 0);
      en  = $urandom_range(0, 1) == 1;
      si  = $urandom_range(0, 1) == 1;
      upd = ($urandom_range(0, 3) == 0);
      ovr = ($urandom_range(0, 3) == 0);
      if (i % 40 == 10) begin
        se = 1'b1;
        repeat (8) cyc();
      end
      cyc();
      if ($urandom_range(0, 60) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
